irq_sched: RTL and testbench
============================

# irq_sched

Interrupt scheduler for the MMU09 board. It takes the UART, CH375 and RTC interrupt requests plus an internal periodic clock tick, and arbitrates them onto the 6809 IRQ and FIRQ lines. Pending, mask and routing state are held in a 4-byte register window at $FE90–$FE93. The address decoder drives `i_sel` for accesses to $FE9x while the I/O area is mapped.

## Interface
Parameters:
- `TICK_DIV`, default 40000: i_eclk cycles per clock tick (50 Hz at 2 MHz E). Legal range 2..2^20.

Ports:
- `i_eclk`  in  1  6809 E clock; all state changes on its rising edge.
- `i_reset`  in  1  reset i_reset, synchronous, active-low; clock i_eclk.
- `i_sel`  in  1  active high; the decoder asserts it for an $FE9x access with the I/O area mapped.
- `i_rw`  in  1  6809 R/W: 1 = read, 0 = write.
- `i_addr`  in  2  register index, taken from address bits [1:0].
- `i_data`  in  8  write data from the CPU.
- `o_data`  out  8  read data.
- `o_data_oe`  out  1  read-data enable, equal to `i_sel & i_rw & i_eclk`.
- `i_uartirq`  in  1  UART request, active low, level.
- `i_chirq`  in  1  CH375 request, active low, level.
- `i_rtcirq`  in  1  RTC request, active low, level.
- `irq_n`  out  1  6809 IRQ, active low, registered.
- `firq_n`  out  1  6809 FIRQ, active low, registered.
- `o_tick`  out  1  one-cycle high pulse on each tick-counter wrap.

## Operation
- Source bits: bit0 UART, bit1 CH375, bit2 RTC, bit3 TICK. Bit0 has the highest priority, bit3 the lowest.
- Level sources:
  - Each one is inverted and passed through a 2-flop synchroniser into `pend[2:0]`.
  - They are not latched: `pend` follows the synchronised input.
- TICK source:
  - 20-bit counter `cnt`; counts only while `tick_en`=1, and is held at 0 while `tick_en`=0.
  - When `cnt`=TICK_DIV-1: `cnt` goes to 0, `pend[3]` is set, and `o_tick`=1 for that cycle.
  - `pend[3]` stays set until it is cleared by software.
- Register map. A write happens on a rising edge with `i_sel`=1 and `i_rw`=0.
  - 0 STATUS. Read: `{4'b0, pend}`. Write: data bit3=1 clears `pend[3]`; all other bits are ignored.
  - 1 MASK. Read/write `mask[3:0]` in data[3:0]; a 1 enables the source. Upper bits read 0.
  - 2 ROUTE. Read/write `route[3:0]`; a 1 sends the source to FIRQ, a 0 to IRQ. Upper bits read 0.
  - 3 CTRL/ID.
    - Write: data bit7 sets `tick_en`; data bit6=1 forces `cnt`=0 that cycle and is not stored.
    - Read: `{tick_en, 4'b0, valid, id[1:0]}`.
    - `act = pend & mask`; `valid = |act`; `id` = index of the lowest set bit of `act`, or 0 when `valid`=0.
- Outputs:
  - `irq_n` is registered from `!(|(act & ~route))`.
  - `firq_n` is registered from `!(|(act & route))`.
- Reads have no side effects.
- `o_data` is combinational from `i_addr` and the current state. It is driven 0 when `o_data_oe`=0.

## Timing
- Reset values, applied on a rising edge with `i_reset`=0:
  - `mask`=0, `route`=0, `tick_en`=0, `cnt`=0, `pend`=0.
  - Synchroniser flops = 0 (inactive).
  - `irq_n`=1, `firq_n`=1, `o_tick`=0.
  - Reset overrides any simultaneous write or tick wrap.
- Latency:
  - A level input falling at edge N appears in `pend` after edge N+2; `irq_n`/`firq_n` fall after edge N+3.
  - Release follows the same 3-cycle path.
- Tick period:
  - Exactly TICK_DIV cycles between `o_tick` pulses while enabled.
  - The first pulse comes TICK_DIV edges after `tick_en` rises with `cnt`=0.
- A MASK or ROUTE write at edge N takes effect on the IRQ lines at edge N+1.
- Simultaneous events:
  - A tick wrap and a STATUS write-1 to bit3 on the same edge: set wins, and `pend[3]`=1.
  - A CTRL write with bit6=1 and a wrap on the same edge: `cnt`=0, and the wrap still sets `pend[3]`.
- Clearing `tick_en` freezes `cnt` to 0 on the next edge and leaves `pend[3]` unchanged.
- `cnt` wraps only via the TICK_DIV-1 compare, never by 20-bit overflow.

## Test plan
- Reset with all inputs active: after the reset edge, `irq_n`=1, `firq_n`=1, and reads of registers 0–3 return 0x00, even with UART/CH375/RTC held low.
- MASK=0x01, ROUTE=0x00, drop `i_uartirq` at edge N:
  - `irq_n`=0 after N+3 while `firq_n` stays 1.
  - Reg3 reads 0x04.
  - Raising `i_uartirq` returns `irq_n` to 1 three edges later.
- MASK=0x07, ROUTE=0x02, CH375 and RTC both low:
  - `firq_n`=0 and `irq_n`=0.
  - Reg3 reads 0x05 (id 1).
  - Writing MASK=0x05 makes `firq_n`=1 one edge later.
- TICK_DIV=4, write reg3=0x80, MASK=0x08:
  - `o_tick` pulses every 4 cycles and `irq_n` goes low.
  - Writing STATUS=0x08 clears `pend[3]`, which sets again at the next wrap.
- TICK_DIV=4: a STATUS=0x08 write on the exact wrap edge leaves `pend[3]`=1.
- TICK_DIV=4: a reg3=0xC0 write mid-count restarts the period, giving the next `o_tick` 4 edges later.

Source files
------------

// File: rtl/irq_sched.sv
// irq_sched: MMU09 interrupt scheduler.
// Arbitrates UART, CH375, RTC and a periodic tick onto IRQ/FIRQ.
module irq_sched #(
    parameter int TICK_DIV = 40000
) (
    input  logic       i_eclk,
    input  logic       i_reset,
    input  logic       i_sel,
    input  logic       i_rw,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_data_oe,
    input  logic       i_uartirq,
    input  logic       i_chirq,
    input  logic       i_rtcirq,
    output logic       irq_n,
    output logic       firq_n,
    output logic       o_tick
);

    localparam logic [19:0] DIV_M1 = 20'(TICK_DIV - 1);

    logic [2:0]  sync1;
    logic [3:0]  pend;
    logic [3:0]  mask;
    logic [3:0]  route;
    logic [3:0]  act;
    logic        tick_en;
    logic [19:0] cnt;
    logic        wrap;
    logic        wr;
    logic        wr_stat;
    logic        wr_mask;
    logic        wr_route;
    logic        wr_ctrl;
    logic        valid;
    logic [1:0]  id;
    logic [7:0]  rdata;
    logic        unused_ok;

    assign wr       = i_sel & ~i_rw;
    assign wr_stat  = wr & (i_addr == 2'd0);
    assign wr_mask  = wr & (i_addr == 2'd1);
    assign wr_route = wr & (i_addr == 2'd2);
    assign wr_ctrl  = wr & (i_addr == 2'd3);

    assign wrap  = tick_en & (cnt == DIV_M1);
    assign act   = pend & mask;
    assign valid = |act;

    assign unused_ok = ^i_data[5:4];

    // Lowest set bit of act wins
    always_comb begin
        id = 2'd0;
        casez (act)
            4'b???1: id = 2'd0;
            4'b??10: id = 2'd1;
            4'b?100: id = 2'd2;
            4'b1000: id = 2'd3;
            default: id = 2'd0;
        endcase
    end

    always_ff @(posedge i_eclk) begin
        if (!i_reset) begin
            sync1   <= 3'b000;
            pend    <= 4'b0000;
            mask    <= 4'b0000;
            route   <= 4'b0000;
            tick_en <= 1'b0;
            cnt     <= 20'd0;
            o_tick  <= 1'b0;
            irq_n   <= 1'b1;
            firq_n  <= 1'b1;
        end else begin
            sync1     <= ~{i_rtcirq, i_chirq, i_uartirq};
            pend[2:0] <= sync1;

            // A wrap beats a simultaneous software clear
            if (wrap) begin
                pend[3] <= 1'b1;
            end else if (wr_stat && i_data[3]) begin
                pend[3] <= 1'b0;
            end

            if (wr_mask) begin
                mask <= i_data[3:0];
            end
            if (wr_route) begin
                route <= i_data[3:0];
            end
            if (wr_ctrl) begin
                tick_en <= i_data[7];
            end

            if (!tick_en || wrap || (wr_ctrl && i_data[6])) begin
                cnt <= 20'd0;
            end else begin
                cnt <= cnt + 20'd1;
            end

            o_tick <= wrap;
            irq_n  <= ~|(act & ~route);
            firq_n <= ~|(act & route);
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (i_addr)
            2'd0:    rdata = {4'b0000, pend};
            2'd1:    rdata = {4'b0000, mask};
            2'd2:    rdata = {4'b0000, route};
            default: rdata = {tick_en, 4'b0000, valid, id};
        endcase
    end

    assign o_data_oe = i_sel & i_rw & i_eclk;
    assign o_data    = o_data_oe ? rdata : 8'h00;

endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched: directed and random checks of irq_sched
// against a cycle-level behavioural model.
module tb_irq_sched;

    localparam int TD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel   = 1'b0;
    logic       rw    = 1'b1;
    logic [1:0] addr  = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic       uart  = 1'b1;
    logic       ch    = 1'b1;
    logic       rtc   = 1'b1;
    logic [7:0] rdata;
    logic       oe;
    logic       irq_n;
    logic       firq_n;
    logic       tick;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    irq_sched #(.TICK_DIV(TD)) dut (
        .i_eclk   (clk),
        .i_reset  (rst_n),
        .i_sel    (sel),
        .i_rw     (rw),
        .i_addr   (addr),
        .i_data   (wdata),
        .o_data   (rdata),
        .o_data_oe(oe),
        .i_uartirq(uart),
        .i_chirq  (ch),
        .i_rtcirq (rtc),
        .irq_n    (irq_n),
        .firq_n   (firq_n),
        .o_tick   (tick)
    );

    // Behavioural model: countdown to next tick, level history
    logic [3:0] m_mask, m_route;
    logic       m_ten, m_p3, m_irq, m_firq, m_tick;
    logic [2:0] m_lv, m_prev;
    int         m_left;
    logic [7:0] last_rd;
    logic       last_tick;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mread(input logic [1:0] a);
        logic [3:0] act;
        logic [1:0] id;
        logic       found;
        act   = {m_p3, m_lv} & m_mask;
        id    = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (act[i] && !found) begin
                id    = 2'(i);
                found = 1'b1;
            end
        end
        case (a)
            2'd0:    return {4'b0, m_p3, m_lv};
            2'd1:    return {4'b0, m_mask};
            2'd2:    return {4'b0, m_route};
            default: return {m_ten, 4'b0, (act != 4'b0), id};
        endcase
    endfunction

    task automatic mstep();
        logic [3:0] act;
        logic       fire, w;
        if (!rst_n) begin
            m_mask = 0; m_route = 0; m_ten = 0; m_p3 = 0;
            m_lv = 0; m_prev = 0; m_left = TD;
            m_irq = 1; m_firq = 1; m_tick = 0;
            return;
        end
        act    = {m_p3, m_lv} & m_mask;
        m_irq  = ((act & ~m_route) == 4'b0);
        m_firq = ((act & m_route) == 4'b0);
        fire   = m_ten && (m_left == 1);
        m_tick = fire;
        if (!m_ten || fire) m_left = TD;
        else m_left = m_left - 1;
        w = sel && !rw;
        if (w && addr == 2'd3 && wdata[6]) m_left = TD;
        if (fire) m_p3 = 1'b1;
        else if (w && addr == 2'd0 && wdata[3]) m_p3 = 1'b0;
        m_lv   = m_prev;
        m_prev = ~{rtc, ch, uart};
        if (w && addr == 2'd1) m_mask = wdata[3:0];
        if (w && addr == 2'd2) m_route = wdata[3:0];
        if (w && addr == 2'd3) m_ten = wdata[7];
    endtask

    task automatic step();
        @(posedge clk);
        mstep();
        #1;
        chk("irq_n", {7'd0, irq_n}, {7'd0, m_irq});
        chk("firq_n", {7'd0, firq_n}, {7'd0, m_firq});
        chk("o_tick", {7'd0, tick}, {7'd0, m_tick});
        if (sel && rw) begin
            chk("rd_data", rdata, mread(addr));
            chk("rd_oe", {7'd0, oe}, 8'd1);
        end else begin
            chk("idle_data", rdata, 8'h00);
        end
        last_rd   = rdata;
        last_tick = tick;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        sel = 1; rw = 0; addr = a; wdata = d;
        step();
        sel = 0; rw = 1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        sel = 1; rw = 1; addr = a;
        step();
        v   = last_rd;
        sel = 0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!last_tick && n <= 20);
    endtask

    logic [7:0] v;
    int         n;

    initial begin
        // Reset with every source active
        uart = 0; ch = 0; rtc = 0; rst_n = 0;
        step();
        step();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk("rst_read", v, 8'h00);
        end
        chk("rst_irq", {7'd0, irq_n}, 8'd1);
        chk("rst_firq", {7'd0, firq_n}, 8'd1);
        uart = 1; ch = 1; rtc = 1; rst_n = 1;
        repeat (3) step();

        // UART to IRQ, three-edge latency both ways
        wr(2'd1, 8'h01);
        wr(2'd2, 8'h00);
        uart = 0;
        step();
        step();
        chk("uart_lat2", {7'd0, irq_n}, 8'd1);
        step();
        chk("uart_irq", {7'd0, irq_n}, 8'd0);
        chk("uart_firq", {7'd0, firq_n}, 8'd1);
        rd(2'd3, v);
        chk("uart_id", v, 8'h04);
        uart = 1;
        step();
        step();
        chk("uart_rel2", {7'd0, irq_n}, 8'd0);
        step();
        chk("uart_rel3", {7'd0, irq_n}, 8'd1);

        // CH375 routed to FIRQ, RTC to IRQ
        wr(2'd1, 8'h07);
        wr(2'd2, 8'h02);
        ch = 0; rtc = 0;
        repeat (3) step();
        chk("both_firq", {7'd0, firq_n}, 8'd0);
        chk("both_irq", {7'd0, irq_n}, 8'd0);
        rd(2'd3, v);
        chk("both_id", v, 8'h05);
        wr(2'd1, 8'h05);
        chk("mask_same", {7'd0, firq_n}, 8'd0);
        step();
        chk("mask_next", {7'd0, firq_n}, 8'd1);
        ch = 1; rtc = 1;
        repeat (3) step();

        // Tick period and software clear
        wr(2'd1, 8'h08);
        wr(2'd2, 8'h00);
        wr(2'd3, 8'h80);
        wait_tick(n);
        chk("tick_first", 8'(n), 8'd4);
        wait_tick(n);
        chk("tick_period", 8'(n), 8'd4);
        step();
        chk("tick_irq", {7'd0, irq_n}, 8'd0);
        wr(2'd0, 8'h08);
        rd(2'd0, v);
        chk("tick_clr", v, 8'h00);
        step();
        chk("tick_wrap", {7'd0, last_tick}, 8'd1);
        rd(2'd0, v);
        chk("tick_reset", v, 8'h08);

        // Clear on the wrap edge loses to the set
        step();
        step();
        wr(2'd0, 8'h08);
        chk("clr_wrap_tick", {7'd0, last_tick}, 8'd1);
        rd(2'd0, v);
        chk("clr_wrap_pend", v, 8'h08);

        // Restart mid-count
        wr(2'd3, 8'hC0);
        wait_tick(n);
        chk("restart", 8'(n), 8'd4);
        wr(2'd3, 8'h00);
        repeat (6) step();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(9) == 0) uart = ~uart;
            if ($urandom_range(9) == 0) ch = ~ch;
            if ($urandom_range(9) == 0) rtc = ~rtc;
            rst_n = ($urandom_range(299) != 0);
            sel   = 0; rw = 1;
            case ($urandom_range(4))
                0: begin
                    sel = 1; rw = 0;
                    addr  = 2'($urandom);
                    wdata = 8'($urandom);
                    if ($urandom_range(3) != 0) wdata[6] = 1'b0;
                end
                1, 2: begin
                    sel = 1; rw = 1;
                    addr = 2'($urandom);
                end
                default: ;
            endcase
            step();
        end
        sel = 0; rw = 1; rst_n = 1;
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
